// File: rtl/seq_mult_worker_pkg.sv
// Shared encodings for the start/busy/done task handshake between block controllers and workers.
package seq_mult_worker_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'b0000,
        FINISH = 4'b0001,
        BUSY   = 4'b0010
    } state_t;

    function automatic logic state_is_busy(state_t s);
        return s == BUSY;
    endfunction

    function automatic logic state_is_done(state_t s);
        return s == FINISH;
    endfunction

    // Iteration counter needs to hold WIDTH-1 and the post-increment WIDTH.
    function automatic int cnt_width(int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/seq_mult_worker_if.sv
// Task handshake bundle: the controller drives request/operands/ack, the worker returns status/result.
interface seq_mult_worker_if #(
    parameter int WIDTH = 8
) ();
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   ack;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, a, b, ack,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b, ack,
        output busy, done, product
    );
endinterface

// File: rtl/seq_mult_worker.sv
// Unsigned shift-add multiplier acting as a task worker, one multiplier bit per cycle.
// Latency: WIDTH cycles from the accepting edge to done; fixed, no early exit.
// Backpressure: done/product held until ack; start ignored unless idle.
module seq_mult_worker
    import seq_mult_worker_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    seq_mult_worker_if.slave bus
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t               state;
    state_t               state_nxt;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   addend;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        cnt;
    logic                 accept;
    logic                 last;

    assign accept = (state == IDLE) && bus.start;
    assign last   = (state == BUSY) && (cnt == CNT_LAST);
    assign addend = mplier[0] ? mcand : '0;

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = bus.start ? BUSY : IDLE;
            BUSY:    state_nxt = last ? FINISH : BUSY;
            FINISH:  state_nxt = bus.ack ? IDLE : FINISH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // acc doubles as the result register, so product survives IDLE until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, bus.a};
            mplier <= bus.b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == BUSY) begin
            acc    <= acc + addend;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    assign bus.busy    = state_is_busy(state);
    assign bus.done    = state_is_done(state);
    assign bus.product = acc;

    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst)
        !(bus.busy && bus.done));

    a_cnt_in_range: assert property (@(posedge clk) disable iff (rst)
        (state == BUSY) |-> (cnt <= CNT_LAST));

endmodule

// File: tb/tb_seq_mult_worker.sv
// Scoreboard bench for seq_mult_worker at WIDTH=8.
module tb_seq_mult_worker;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;

    seq_mult_worker_if #(.WIDTH(WIDTH)) mif ();

    seq_mult_worker #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [2*WIDTH-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        mif.start = 1'b1;
        mif.a     = a;
        mif.b     = b;
        exp_q.push_back({{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b});
        @(negedge clk);
        mif.start = 1'b0;
    endtask

    // Counts busy cycles; optionally pokes start (and ack a cycle later) mid-run.
    task automatic run_busy(input int inj, output int cnt);
        cnt = 0;
        while (mif.busy === 1'b1 && cnt < 40) begin
            cnt++;
            mif.start = (inj != 0 && cnt == inj);
            mif.ack   = (inj != 0 && cnt == inj + 1);
            if (inj != 0 && cnt == inj) begin
                mif.a = 8'd2;
                mif.b = 8'd2;
            end
            @(negedge clk);
        end
        mif.start = 1'b0;
        mif.ack   = 1'b0;
    endtask

    task automatic finish_check(input int hold, output logic [2*WIDTH-1:0] e);
        int w;
        w = 0;
        while (mif.done !== 1'b1 && w < 40) begin
            w++;
            @(negedge clk);
        end
        check_val("done_rise", mif.done, 1);
        check_val("busy_in_finish", mif.busy, 0);
        if (exp_q.size() == 0) begin
            check_val("sb_nonempty", 0, 1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check_val("product", mif.product, e);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_done", mif.done, 1);
            check_val("hold_product", mif.product, e);
        end
    endtask

    task automatic do_ack(input logic [2*WIDTH-1:0] e);
        mif.ack = 1'b1;
        @(negedge clk);
        mif.ack = 1'b0;
        check_val("ack_done_low", mif.done, 0);
        check_val("ack_busy_low", mif.busy, 0);
        check_val("idle_product_kept", mif.product, e);
    endtask

    task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input int inj, input int hold);
        int cnt;
        logic [2*WIDTH-1:0] e;
        issue(a, b);
        run_busy(inj, cnt);
        check_val("busy_len", cnt, WIDTH);
        finish_check(hold, e);
        do_ack(e);
    endtask

    initial begin
        int cnt;
        logic [2*WIDTH-1:0] e;

        rst       = 1'b1;
        mif.start = 1'b0;
        mif.a     = '0;
        mif.b     = '0;
        mif.ack   = 1'b0;
        #1;
        check_val("rst_busy", mif.busy, 0);
        check_val("rst_done", mif.done, 0);
        check_val("rst_product", mif.product, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ack while idle must not start or complete anything
        mif.ack = 1'b1;
        @(negedge clk);
        mif.ack = 1'b0;
        check_val("idle_ack_busy", mif.busy, 0);
        check_val("idle_ack_done", mif.done, 0);

        op(8'd13, 8'd11, 0, 3);
        op(8'd255, 8'd255, 0, 0);
        op(8'd0, 8'd200, 0, 0);
        op(8'd1, 8'd128, 0, 0);

        // start (and a following ack) during BUSY are ignored
        op(8'd7, 8'd6, 3, 0);

        // ack and start together in FINISH: back to IDLE, start not taken
        issue(8'd4, 8'd5);
        run_busy(0, cnt);
        check_val("busy_len_as", cnt, WIDTH);
        finish_check(0, e);
        mif.ack   = 1'b1;
        mif.start = 1'b1;
        mif.a     = 8'd9;
        mif.b     = 8'd9;
        @(negedge clk);
        mif.ack = 1'b0;
        check_val("ack_start_busy", mif.busy, 0);
        check_val("ack_start_done", mif.done, 0);
        exp_q.push_back(16'd81);
        @(negedge clk);
        mif.start = 1'b0;
        check_val("held_start_accepted", mif.busy, 1);
        run_busy(0, cnt);
        check_val("busy_len_held", cnt, WIDTH);
        finish_check(0, e);
        do_ack(e);

        // async reset four cycles into BUSY discards the run
        mif.start = 1'b1;
        mif.a     = 8'd100;
        mif.b     = 8'd100;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("pre_rst_busy", mif.busy, 1);
        #2 rst = 1'b1;
        #1;
        check_val("mid_rst_busy", mif.busy, 0);
        check_val("mid_rst_done", mif.done, 0);
        check_val("mid_rst_product", mif.product, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_done", mif.done, 0);
        op(8'd3, 8'd5, 0, 0);

        // long hold with ack low
        op(8'd200, 8'd3, 0, 20);
        op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 1);

        check_val("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seq_mult_worker.md
# seq_mult_worker

Multi-cycle unsigned shift-add multiplier that acts as the worker end of the start/busy/done task handshake used by the team's block controllers. A controller pulses or holds `start` with operands on `a`/`b`. The worker latches them, iterates one bit per cycle, then raises `done` together with a stable `product`. `done` stays high until the controller returns `ack`. The `done` output is the completion flag a controller samples to leave its busy state.

## Interface
Parameters:
- `WIDTH`, default 8: operand width in bits; product is 2*WIDTH bits.

Ports:
- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: request; sampled only in IDLE.
- `a`, input, WIDTH: multiplicand; sampled with `start`.
- `b`, input, WIDTH: multiplier; sampled with `start`.
- `ack`, input, 1: controller has consumed the result; sampled only in FINISH.
- `busy`, output, 1: high while in BUSY.
- `done`, output, 1: high while in FINISH.
- `product`, output, 2*WIDTH: result; valid while `done` is high.

## Operation
- State register is 4 bits wide with three legal states:
  - IDLE = 4'b0000
  - FINISH = 4'b0001
  - BUSY = 4'b0010
- Any other encoding returns to IDLE on the next edge.
- **IDLE:**
  - On `start`=1, latch `a` into `mcand` (2*WIDTH, zero-extended) and `b` into `mplier`.
  - In the same edge, clear `acc`, set `cnt`=0 and go to BUSY.
  - With `start`=0, stay in IDLE.
- **BUSY**, each cycle:
  - `acc` += `mplier[0]` ? `mcand` : 0, computed at 2*WIDTH bits with no overflow possible.
  - `mcand` <<= 1.
  - `mplier` >>= 1.
  - `cnt`++.
  - When `cnt`==WIDTH-1 at the edge, the final accumulate happens and the state goes to FINISH.
  - `start` and `ack` are ignored in BUSY.
- **FINISH:**
  - `product` = `acc`, held constant.
  - On `ack`=1, go to IDLE; `start` in that same cycle is ignored.
  - With `ack`=0, stay in FINISH indefinitely.
- `product` keeps its last value through IDLE until the next accepted `start` clears `acc`.
- `cnt` is sized $clog2(WIDTH)+1 bits.
- No early termination when `mplier` becomes zero; latency is fixed.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `product`=0, `acc`=0, `cnt`=0.
- `busy` and `done` decode directly from the state register; they are never high together.
- `start` accepted at edge E0:
  - `busy` is high after E0 through the edge E0+WIDTH.
  - `done` is high from just after E0+WIDTH.
  - Latency from accepting edge to `done` is WIDTH cycles.
- `ack` sampled at edge Ek in FINISH: `done` low after Ek.
- Earliest next acceptance is at Ek+1, so back-to-back throughput is one result per WIDTH+2 cycles with a one-cycle `ack`.
- `start` held high continuously is accepted again only after the return to IDLE.
- `rst` asserted at any point, including mid-BUSY or FINISH: immediately and asynchronously forces the reset values. The in-flight result is discarded and no `done` is produced.

## Structure
- Shared package holds the state encodings (IDLE, FINISH, BUSY as 4-bit constants) so controllers and workers decode the same values.
- Single module, no sub-module required.
- The counter and datapath registers live in one clocked process; next-state logic is purely combinational with a default assignment to IDLE.

## Test plan
All scenarios use WIDTH=8.
- **Basic multiply:** `start` for one cycle with a=13, b=11 -> `busy` high for exactly 8 cycles, then `done`=1 with `product`=143, held until `ack`.
- **Full scale:** a=255, b=255 -> `product`=65025.
  - Also a=0, b=200 -> `product`=0.
  - Also a=1, b=128 -> `product`=128.
- **Start during BUSY:** `start` pulsed mid-BUSY with a=2, b=2 -> ignored; the first result (a=7, b=6 -> 42) completes unaltered with unchanged latency.
- **Ack and start together in FINISH:** `ack`=1 and `start`=1 in the same cycle -> IDLE next cycle, no new operation. `start` held one more cycle -> accepted, `busy` rises.
- **Reset mid-operation:** `rst` asserted 4 cycles into BUSY -> `busy`, `done`, `product` go to 0 immediately. After release, a new a=3, b=5 run yields 15 with normal latency.
- **Held ack:** `done` held for 20 cycles with `ack`=0 -> `product` stable throughout. An `ack` sampled in IDLE or BUSY has no effect.
